// File: rtl/rfd_multichan_sample_counter.sv
// Multi-channel RFD sample counter.
// NCH independent counters, each wrapping at its own terminal count, with a
// per-channel continuous/one-shot mode, sticky one-shot completion, per-channel
// and global synchronous clears, and registered aggregate flags.
module rfd_multichan_sample_counter #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned CTR_SIZE = 10
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NCH-1:0]          en,
  input  logic [NCH-1:0]          clr,
  input  logic                    sync_clr,
  input  logic [NCH-1:0]          oneshot,
  input  logic [NCH*CTR_SIZE-1:0] sample_max,
  output logic [NCH-1:0]          timeout,
  output logic [NCH-1:0]          last_sample_cnt,
  output logic [NCH-1:0]          done,
  output logic [NCH*CTR_SIZE-1:0] count,
  output logic                    any_timeout,
  output logic                    all_done
);

  logic [CTR_SIZE-1:0] cnt_q [NCH];
  logic [CTR_SIZE-1:0] cnt_d [NCH];
  logic [CTR_SIZE-1:0] max_w [NCH];
  logic [NCH-1:0]      done_q, done_d;
  logic [NCH-1:0]      timeout_q, timeout_d;
  logic [NCH-1:0]      kill, term, armed;
  logic                any_timeout_q, all_done_q;

  // Unpack the per-channel terminal counts.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      max_w[i] = sample_max[i*CTR_SIZE +: CTR_SIZE];
    end
  end

  // Per-channel decode: clear, terminal (>= so a lowered max wraps at once), armed.
  always_comb begin
    kill  = '0;
    term  = '0;
    armed = '0;
    for (int i = 0; i < NCH; i++) begin
      kill[i]  = clr[i] | sync_clr;
      term[i]  = (cnt_q[i] >= max_w[i]);
      armed[i] = ~done_q[i];
    end
  end

  // Next-state per channel; clear beats everything, then wrap, then increment.
  always_comb begin
    done_d    = done_q;
    timeout_d = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (kill[i]) begin
        cnt_d[i]  = '0;
        done_d[i] = 1'b0;
      end else if (en[i] && armed[i] && term[i]) begin
        cnt_d[i]     = '0;
        timeout_d[i] = 1'b1;
        // Mode is only consulted at the wrap itself.
        if (oneshot[i]) begin
          done_d[i] = 1'b1;
        end
      end else if (en[i] && armed[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Counter, flag and aggregate registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      done_q        <= '0;
      timeout_q     <= '0;
      any_timeout_q <= 1'b0;
      all_done_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      // Aggregates are built from next-state so they line up with the per-channel flags.
      any_timeout_q <= |timeout_d;
      all_done_q    <= &done_d;
    end
  end

  // Output packing; last_sample_cnt is a pure decode independent of en.
  always_comb begin
    count = '0;
    for (int i = 0; i < NCH; i++) begin
      count[i*CTR_SIZE +: CTR_SIZE] = cnt_q[i];
    end
  end

  assign last_sample_cnt = term & armed;
  assign timeout         = timeout_q;
  assign done            = done_q;
  assign any_timeout     = any_timeout_q;
  assign all_done        = all_done_q;

endmodule
